// File: rtl/toy_mem_responder.sv
// Memory-side responder for the RISC_TOY instruction and data buses.
// One shared word-addressed array; reads return after a fixed LAT-cycle latency
// through a {valid, data} shift pipeline. Sticky range error and saturating
// per-type access counters are kept for debug.
module toy_mem_responder #(
    parameter int unsigned AW  = 10,
    parameter int unsigned LAT = 1,
    parameter int unsigned CW  = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IREQ,
    input  logic [29:0]   IADDR,
    output logic [31:0]   INSTR,
    output logic          IVALID,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    output logic          DVALID,
    output logic          ERR,
    output logic [CW-1:0] IRD_CNT,
    output logic [CW-1:0] DRD_CNT,
    output logic [CW-1:0] DWR_CNT
);

    if (LAT == 0 || LAT > 4) begin : g_bad_lat
        $error("toy_mem_responder: LAT must be in 1..4");
    end

    localparam int unsigned Depth = 1 << AW;

    // Storage is deliberately not reset so contents survive RSTN.
    logic [31:0] r_mem [Depth];

    logic        w_i_oor;
    logic        w_d_oor;
    logic        w_d_rd;
    logic        w_d_wr;
    logic [31:0] w_i_rdata;
    logic [31:0] w_d_rdata;

    // Any address bit at or above AW makes the access out of range.
    assign w_i_oor   = (IADDR >> AW) != 30'd0;
    assign w_d_oor   = (DADDR >> AW) != 30'd0;
    assign w_d_rd    = DREQ & ~DRW;
    assign w_d_wr    = DREQ & DRW;
    assign w_i_rdata = w_i_oor ? 32'd0 : r_mem[IADDR[AW-1:0]];
    assign w_d_rdata = w_d_oor ? 32'd0 : r_mem[DADDR[AW-1:0]];

    // Array write; a same-edge read sees the old word (read-before-write).
    always_ff @(posedge CLK) begin
        if (w_d_wr && !w_d_oor) begin
            r_mem[DADDR[AW-1:0]] <= DWDATA;
        end
    end

    logic [LAT-1:0] r_iv;
    logic [LAT-1:0] r_dv;
    logic [31:0]    r_id [LAT];
    logic [31:0]    r_dd [LAT];

    // Stage 0: capture read data from the array on the request edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_iv[0] <= 1'b0;
            r_dv[0] <= 1'b0;
            r_id[0] <= 32'd0;
            r_dd[0] <= 32'd0;
        end else begin
            r_iv[0] <= IREQ;
            r_dv[0] <= w_d_rd;
            if (IREQ) begin
                r_id[0] <= w_i_rdata;
            end
            if (w_d_rd) begin
                r_dd[0] <= w_d_rdata;
            end
        end
    end

    // Stages 1..LAT-1: shift {valid, data}; data only moves with a valid so the
    // last stage holds its value between returns.
    for (genvar g = 1; g < LAT; g++) begin : g_stage
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_iv[g] <= 1'b0;
                r_dv[g] <= 1'b0;
                r_id[g] <= 32'd0;
                r_dd[g] <= 32'd0;
            end else begin
                r_iv[g] <= r_iv[g-1];
                r_dv[g] <= r_dv[g-1];
                if (r_iv[g-1]) begin
                    r_id[g] <= r_id[g-1];
                end
                if (r_dv[g-1]) begin
                    r_dd[g] <= r_dd[g-1];
                end
            end
        end
    end

    assign IVALID = r_iv[LAT-1];
    assign DVALID = r_dv[LAT-1];
    assign INSTR  = r_id[LAT-1];
    assign DRDATA = r_dd[LAT-1];

    logic          r_err;
    logic [CW-1:0] r_ird_cnt;
    logic [CW-1:0] r_drd_cnt;
    logic [CW-1:0] r_dwr_cnt;

    // Sticky range error and saturating access counters.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_err     <= 1'b0;
            r_ird_cnt <= '0;
            r_drd_cnt <= '0;
            r_dwr_cnt <= '0;
        end else begin
            if ((IREQ && w_i_oor) || (DREQ && w_d_oor)) begin
                r_err <= 1'b1;
            end
            if (IREQ && r_ird_cnt != '1) begin
                r_ird_cnt <= r_ird_cnt + 1'b1;
            end
            if (w_d_rd && r_drd_cnt != '1) begin
                r_drd_cnt <= r_drd_cnt + 1'b1;
            end
            if (w_d_wr && r_dwr_cnt != '1) begin
                r_dwr_cnt <= r_dwr_cnt + 1'b1;
            end
        end
    end

    assign ERR     = r_err;
    assign IRD_CNT = r_ird_cnt;
    assign DRD_CNT = r_drd_cnt;
    assign DWR_CNT = r_dwr_cnt;

endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench for toy_mem_responder: three instances (LAT=1/CW=4, LAT=3, LAT=4)
// share one stimulus bus and one reset.
module tb_toy_mem_responder;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;

    logic [31:0] instr_1, drdata_1, instr_3, drdata_3, instr_4, drdata_4;
    logic        ivalid_1, dvalid_1, err_1, ivalid_3, dvalid_3, err_3;
    logic        ivalid_4, dvalid_4, err_4;
    logic [3:0]  ird_1, drd_1, dwr_1;
    logic [15:0] ird_3, drd_3, dwr_3, ird_4, drd_4, dwr_4;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    toy_mem_responder #(.AW(10), .LAT(1), .CW(4)) u_l1 (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(instr_1), .IVALID(ivalid_1),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(drdata_1),
        .DVALID(dvalid_1), .ERR(err_1), .IRD_CNT(ird_1), .DRD_CNT(drd_1), .DWR_CNT(dwr_1)
    );

    toy_mem_responder #(.AW(10), .LAT(3), .CW(16)) u_l3 (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(instr_3), .IVALID(ivalid_3),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(drdata_3),
        .DVALID(dvalid_3), .ERR(err_3), .IRD_CNT(ird_3), .DRD_CNT(drd_3), .DWR_CNT(dwr_3)
    );

    toy_mem_responder #(.AW(10), .LAT(4), .CW(16)) u_l4 (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(instr_4), .IVALID(ivalid_4),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(drdata_4),
        .DVALID(dvalid_4), .ERR(err_4), .IRD_CNT(ird_4), .DRD_CNT(drd_4), .DWR_CNT(dwr_4)
    );

    typedef struct {
        logic        ireq;
        logic [29:0] iaddr;
        logic        dreq;
        logic        drw;
        logic [29:0] daddr;
        logic [31:0] dwdata;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_dv;
        logic [31:0] e_drdata;
        int          e_ird;
        int          e_drd;
        int          e_dwr;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [29:0] iaddr, input logic dreq,
                         input logic drw, input logic [29:0] daddr, input logic [31:0] dwdata);
        IREQ   = ireq;
        IADDR  = iaddr;
        DREQ   = dreq;
        DRW    = drw;
        DADDR  = daddr;
        DWDATA = dwdata;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int exp_ird;

        // ireq iaddr dreq drw daddr dwdata | iv instr dv drdata | ird drd dwr (LAT=1 view)
        tbl[0]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd5, 32'hDEADBEEF,
                    1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 1};
        tbl[1]  = '{1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'h0,
                    1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 0, 1, 1};
        tbl[2]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd0, 32'h10,
                    1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1, 2};
        tbl[3]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd1, 32'h11,
                    1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1, 3};
        tbl[4]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd2, 32'h12,
                    1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1, 4};
        tbl[5]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd3, 32'h13,
                    1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1, 5};
        tbl[6]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd7, 32'h11111111,
                    1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1, 6};
        tbl[7]  = '{1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0,
                    1'b1, 32'h10, 1'b0, 32'hDEADBEEF, 1, 1, 6};
        tbl[8]  = '{1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0,
                    1'b0, 32'h10, 1'b0, 32'hDEADBEEF, 1, 1, 6};
        tbl[9]  = '{1'b1, 30'd7, 1'b1, 1'b1, 30'd7, 32'hAAAA5555,
                    1'b1, 32'h11111111, 1'b0, 32'hDEADBEEF, 2, 1, 7};
        tbl[10] = '{1'b1, 30'd7, 1'b0, 1'b0, 30'd0, 32'h0,
                    1'b1, 32'hAAAA5555, 1'b0, 32'hDEADBEEF, 3, 1, 7};
        tbl[11] = '{1'b1, 30'd1, 1'b1, 1'b0, 30'd7, 32'h0,
                    1'b1, 32'h11, 1'b1, 32'hAAAA5555, 4, 2, 7};
        tbl[12] = '{1'b0, 30'd0, 1'b0, 1'b1, 30'd5, 32'h12345678,
                    1'b0, 32'h11, 1'b0, 32'hAAAA5555, 4, 2, 7};
        tbl[13] = '{1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'h0,
                    1'b0, 32'h11, 1'b1, 32'hDEADBEEF, 4, 3, 7};

        RSTN = 1'b0;
        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        repeat (3) @(negedge CLK);
        chk("rst_instr",  instr_1,  32'd0);
        chk("rst_drdata", drdata_1, 32'd0);
        chk("rst_ivalid", {31'd0, ivalid_1}, 32'd0);
        chk("rst_dvalid", {31'd0, dvalid_4}, 32'd0);
        chk("rst_err",    {31'd0, err_1},    32'd0);
        chk("rst_cnt",    {16'd0, ird_4 | drd_4 | dwr_4}, 32'd0);
        RSTN = 1'b1;

        // Table: main read/write/collision behaviour at LAT=1.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].drw, tbl[i].daddr,
                  tbl[i].dwdata);
            tick();
            chk($sformatf("v%0d_ivalid", i), {31'd0, ivalid_1}, {31'd0, tbl[i].e_iv});
            chk($sformatf("v%0d_instr", i),  instr_1,  tbl[i].e_instr);
            chk($sformatf("v%0d_dvalid", i), {31'd0, dvalid_1}, {31'd0, tbl[i].e_dv});
            chk($sformatf("v%0d_drdata", i), drdata_1, tbl[i].e_drdata);
            chk($sformatf("v%0d_ird", i), {28'd0, ird_1}, tbl[i].e_ird);
            chk($sformatf("v%0d_drd", i), {28'd0, drd_1}, tbl[i].e_drd);
            chk($sformatf("v%0d_dwr", i), {28'd0, dwr_1}, tbl[i].e_dwr);
        end
        chk("tbl_err", {31'd0, err_1}, 32'd0);

        // LAT=3: back-to-back I-reads of 0..3 return back-to-back.
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, 30'(c), 1'b0, 1'b0, 30'd0, 32'd0);
            else       drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
            tick();
            chk($sformatf("l3_ivalid_c%0d", c), {31'd0, ivalid_3},
                (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5) chk($sformatf("l3_instr_c%0d", c), instr_3, 32'h10 + c - 2);
        end
        chk("l3_instr_hold", instr_3, 32'h13);

        // Out-of-range write dropped, read returns 0 with a pulse, ERR sticky.
        drive(1'b0, 30'd0, 1'b1, 1'b1, 30'h400, 32'hCAFEF00D);
        tick();
        chk("oor_err_set", {31'd0, err_1}, 32'd1);
        drive(1'b0, 30'd0, 1'b1, 1'b0, 30'h400, 32'd0);
        tick();
        chk("oor_dvalid", {31'd0, dvalid_1}, 32'd1);
        chk("oor_drdata", drdata_1, 32'd0);
        drive(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        tick();
        chk("oor_mem0", instr_1, 32'h10);
        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        repeat (100) tick();
        chk("oor_err_sticky", {31'd0, err_1}, 32'd1);
        chk("oor_err_l4",     {31'd0, err_4}, 32'd1);
        chk("oor_drd_cnt", {28'd0, drd_1}, 32'd4);
        chk("oor_dwr_cnt", {28'd0, dwr_1}, 32'd8);

        // CW=4 saturation: 9 I-reads so far, then 20 more.
        exp_ird = 9;
        chk("sat_start", {28'd0, ird_1}, exp_ird);
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 30'(n % 4), 1'b0, 1'b0, 30'd0, 32'd0);
            tick();
            exp_ird = (exp_ird < 15) ? exp_ird + 1 : 15;
            chk($sformatf("sat_ird_n%0d", n), {28'd0, ird_1}, exp_ird);
        end
        chk("nosat_ird_l3", {16'd0, ird_3}, 32'd29);
        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        repeat (6) tick();

        // LAT=4: reset with two reads in flight.
        drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'd0);
        tick();
        drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd1, 32'd0);
        tick();
        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        #2 RSTN = 1'b0;
        #1;
        chk("mid_rst_dvalid", {31'd0, dvalid_4}, 32'd0);
        chk("mid_rst_drdata", drdata_4, 32'd0);
        chk("mid_rst_drd",    {16'd0, drd_4}, 32'd0);
        chk("mid_rst_dwr",    {16'd0, dwr_4}, 32'd0);
        chk("mid_rst_ird",    {16'd0, ird_4}, 32'd0);
        chk("mid_rst_err",    {31'd0, err_4}, 32'd0);
        chk("mid_rst_instr1", instr_1, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("post_rst_dvalid_c%0d", c), {31'd0, dvalid_4}, 32'd0);
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'd0);
            else        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
            tick();
            chk($sformatf("l4_dvalid_c%0d", c), {31'd0, dvalid_4}, (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) chk("l4_retained", drdata_4, 32'hDEADBEEF);
        end
        chk("l4_drd_cnt", {16'd0, drd_4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
